// File: rtl/df_frame_wb.sv
// Write-back buffer for deblocking-filter frame stores: FIFO plus coalescing of
// address-contiguous words into aligned bursts of up to 4 beats.

module df_wb_link (
  input  logic [20:0] prev_addr,
  input  logic [20:0] cur_addr,
  input  logic        lane_en,
  output logic        link
);
  assign link = lane_en && (cur_addr == prev_addr + 21'd1);
endmodule

module df_frame_wb #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        final_frame_RAM_wr,
  input  logic [20:0] final_frame_RAM_addr,
  input  logic [31:0] final_frame_RAM_din,
  input  logic        end_of_lastMB_DF,
  output logic        mem_req,
  output logic [20:0] mem_addr,
  output logic [2:0]  mem_len,
  input  logic        mem_ack,
  output logic        mem_wvalid,
  output logic [31:0] mem_wdata,
  input  logic        mem_wready,
  output logic        fifo_full,
  output logic        overflow,
  output logic        frame_flush_done
);
  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam int CW        = DEPTH_LOG2 + 1;
  localparam int WW        = $clog2(TIMEOUT + 1);
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [20:0] addr;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  wb_entry_t                    mem [DEPTH];
  logic [DEPTH_LOG2-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]                count, count_nxt;
  logic [WW-1:0]                wait_cnt;
  logic [2:0]                   beat_cnt, cap, blen;
  logic [NUM_LANES-1:0][20:0]   win_addr;
  logic [NUM_LANES-1:0]         link;
  state_t                       state, state_nxt;
  logic                         push, pop, launch, flush_pending, done_c, run_ok;

  assign push = final_frame_RAM_wr && !fifo_full;
  assign pop  = (state == DATA) && mem_wready;

  // Head window: the first NUM_LANES entries, each lane checks it continues its predecessor.
  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_win
      assign win_addr[i] = mem[rd_ptr + DEPTH_LOG2'(i)].addr;
    end
    assign link[0] = 1'b1;
    for (genvar i = 1; i < NUM_LANES; i++) begin : g_link
      df_wb_link u_link (
        .prev_addr (win_addr[i-1]),
        .cur_addr  (win_addr[i]),
        .lane_en   ((cap > 3'(i)) && (count > CW'(i))),
        .link      (link[i])
      );
    end
  endgenerate

  // Bursts stay inside one 4-word-aligned group.
  assign cap = 3'd4 - {1'b0, win_addr[0][1:0]};

  always_comb begin
    blen   = 3'd1;
    run_ok = 1'b1;
    for (int i = 1; i < NUM_LANES; i++) begin
      run_ok = run_ok && link[i];
      if (run_ok) blen = 3'(i + 1);
    end
  end

  assign launch = (state == IDLE) && (count != '0) &&
                  ((count >= CW'(4)) || (blen == cap) || flush_pending ||
                   (wait_cnt == WW'(TIMEOUT)));

  assign done_c           = flush_pending && (state == IDLE) && (count == '0) && !push;
  assign frame_flush_done = done_c;
  assign mem_req          = (state == REQ);
  assign mem_wvalid       = (state == DATA);
  assign mem_wdata        = (state == DATA) ? mem[rd_ptr].data : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (launch) state_nxt = REQ;
      REQ:     if (mem_ack) state_nxt = DATA;
      DATA:    if (mem_wready && beat_cnt == 3'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: final_frame_RAM_addr, data: final_frame_RAM_din};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fifo_full     <= 1'b0;
      overflow      <= 1'b0;
      wait_cnt      <= '0;
      beat_cnt      <= '0;
      mem_addr      <= '0;
      mem_len       <= '0;
      flush_pending <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      fifo_full <= (count_nxt == CW'(DEPTH));
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      // A write against a full FIFO is lost even if a pop frees a slot this cycle.
      if (final_frame_RAM_wr && fifo_full) overflow <= 1'b1;
      if (launch || count == '0)
        wait_cnt <= '0;
      else if (state == IDLE && wait_cnt != WW'(TIMEOUT))
        wait_cnt <= wait_cnt + WW'(1);
      if (launch) begin
        mem_addr <= win_addr[0];
        mem_len  <= blen;
      end
      if (state == REQ && mem_ack) beat_cnt <= mem_len;
      else if (pop)                beat_cnt <= beat_cnt - 3'd1;
      flush_pending <= done_c ? 1'b0 : (flush_pending || end_of_lastMB_DF);
    end
  end
endmodule

// File: tb/tb_df_frame_wb.sv
// Bench for df_frame_wb: queue-based reference model checked every cycle,
// first-burst vector table, directed corner sequences and a random phase.

module tb_df_frame_wb;
  localparam int TIMEOUT = 16;
  localparam int DEPTH   = 16;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        wr = 1'b0, eolmb = 1'b0, mem_ack = 1'b0, mem_wready = 1'b0;
  logic [20:0] waddr = '0;
  logic [31:0] wdin = '0;
  logic        mem_req, mem_wvalid, fifo_full, overflow, frame_flush_done;
  logic [20:0] mem_addr;
  logic [2:0]  mem_len;
  logic [31:0] mem_wdata;

  always #5 clk = ~clk;

  df_frame_wb #(.DEPTH_LOG2(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .final_frame_RAM_wr(wr), .final_frame_RAM_addr(waddr), .final_frame_RAM_din(wdin),
    .end_of_lastMB_DF(eolmb),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len), .mem_ack(mem_ack),
    .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata), .mem_wready(mem_wready),
    .fifo_full(fifo_full), .overflow(overflow), .frame_flush_done(frame_flush_done)
  );

  int pass_cnt = 0, chk_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [20:0] addr; logic [31:0] data; } ent_t;
  typedef struct { logic [20:0] addr; logic [2:0] len; } burst_t;

  ent_t   q[$], q_last[$];
  burst_t bursts[$];
  bit     ovf, pend, pend_last, active, active_last, prev_req;
  bit     launch_now, exp_launch, m_push, m_pop, done_exp;
  int     idle_run, idle_last, beats_left, pops, done_pulses, exp_l, cap_l;
  logic [20:0] b_addr;
  logic [2:0]  b_len;

  // Expected burst length: min(group remainder, entries held, contiguous run).
  function automatic int model_len(input ent_t qq[$]);
    int cap, lim, run;
    if (qq.size() == 0) return 0;
    cap = 4 - int'(qq[0].addr[1:0]);
    lim = (cap < qq.size()) ? cap : qq.size();
    run = 1;
    while (run < lim && qq[run].addr == qq[run-1].addr + 21'd1) run++;
    return run;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete(); q_last.delete();
      ovf = 0; pend = 0; pend_last = 0; active = 0; active_last = 0; prev_req = 0;
      idle_run = 0; idle_last = 0; beats_left = 0;
    end else begin
      launch_now = mem_req && !prev_req;
      exp_l      = model_len(q_last);
      cap_l      = (q_last.size() > 0) ? 4 - int'(q_last[0].addr[1:0]) : 0;
      exp_launch = !active_last && q_last.size() > 0 &&
                   (q_last.size() >= 4 || exp_l == cap_l || pend_last || idle_last >= TIMEOUT);
      if (launch_now || exp_launch) check("launch_timing", 64'(launch_now), 64'(exp_launch));
      if (launch_now) begin
        check("burst_addr", 64'(mem_addr), (q_last.size() > 0) ? 64'(q_last[0].addr) : 64'hx);
        check("burst_len", 64'(mem_len), 64'(exp_l));
        b_addr = mem_addr; b_len = mem_len; active = 1; idle_run = 0;
        bursts.push_back('{mem_addr, mem_len});
      end else if (mem_req) begin
        check("req_addr_stable", 64'(mem_addr), 64'(b_addr));
        check("req_len_stable", 64'(mem_len), 64'(b_len));
      end
      check("busy_vs_model", 64'(mem_req | mem_wvalid), 64'(active));
      if (mem_wvalid) begin
        check("beat_in_burst", 64'(beats_left > 0), 64'd1);
        if (q.size() > 0) check("wdata", 64'(mem_wdata), 64'(q[0].data));
      end
      check("fifo_full", 64'(fifo_full), 64'(q.size() == DEPTH));
      check("overflow", 64'(overflow), 64'(ovf));
      m_push   = wr && q.size() < DEPTH;
      done_exp = pend && !active && q.size() == 0 && !m_push;
      if (done_exp || frame_flush_done) check("flush_done", 64'(frame_flush_done), 64'(done_exp));
      if (frame_flush_done) done_pulses++;

      q_last = q; pend_last = pend; active_last = active; idle_last = idle_run;
      if (!active) begin
        if (q.size() == 0) idle_run = 0;
        else if (idle_run < TIMEOUT) idle_run++;
      end
      if (wr && q.size() >= DEPTH) ovf = 1;
      m_pop = mem_wvalid && mem_wready;
      if (mem_req && mem_ack) beats_left = int'(b_len);
      if (m_pop) begin
        if (q.size() > 0) void'(q.pop_front());
        pops++;
        if (beats_left > 0) beats_left--;
        if (beats_left == 0) active = 0;
      end
      if (m_push) q.push_back('{waddr, wdin});
      pend = done_exp ? 1'b0 : (pend | eolmb);
      prev_req = mem_req;
    end
  end

  // ---------------- memory-side responder ----------------
  int mode = 0, req_age = 0;
  always @(posedge clk) begin
    #1;
    req_age = mem_req ? req_age + 1 : 0;
    case (mode)
      0: begin mem_ack = 1; mem_wready = 1; end
      1: begin mem_ack = ($urandom_range(0, 2) != 0); mem_wready = ($urandom_range(0, 3) != 0); end
      2: begin mem_ack = 0; mem_wready = 1; end
      default: begin mem_ack = (req_age >= 6); mem_wready = ~mem_wready; end
    endcase
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_word(input logic [20:0] a);
    wr = 1; waddr = a; wdin = $urandom;
    @(posedge clk); #1;
    wr = 0;
  endtask

  task automatic pulse_end();
    eolmb = 1;
    @(posedge clk); #1;
    eolmb = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset_n = 0; wr = 0; eolmb = 0;
    @(posedge clk); #1;
    reset_n = 1;
    bursts.delete(); pops = 0; done_pulses = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    @(negedge clk);
    while ((q.size() != 0 || active || mem_req) && k < budget) begin
      @(negedge clk); k++;
    end
    check(name, 64'(k < budget), 64'd1);
  endtask

  typedef struct {
    int          n;
    logic [20:0] a[4];
    logic [2:0]  exp_len;
  } vec_t;
  vec_t vt[9];

  function automatic vec_t mkv(input int n, input logic [20:0] a0, a1, a2, a3, input logic [2:0] l);
    vec_t v;
    v.n = n; v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3; v.exp_len = l;
    return v;
  endfunction

  initial begin
    logic [20:0] ra;
    bit seen;
    vt[0] = mkv(4, 21'h100, 21'h101, 21'h102, 21'h103, 3'd4);
    vt[1] = mkv(3, 21'h102, 21'h103, 21'h104, 21'h0, 3'd2);
    vt[2] = mkv(2, 21'h103, 21'h104, 21'h0, 21'h0, 3'd1);
    vt[3] = mkv(3, 21'h010, 21'h011, 21'h013, 21'h0, 3'd2);
    vt[4] = mkv(1, 21'h055, 21'h0, 21'h0, 21'h0, 3'd1);
    vt[5] = mkv(4, 21'h1FFFFC, 21'h1FFFFD, 21'h1FFFFE, 21'h1FFFFF, 3'd4);
    vt[6] = mkv(2, 21'h1FFFFF, 21'h000000, 21'h0, 21'h0, 3'd1);
    vt[7] = mkv(4, 21'h200, 21'h200, 21'h201, 21'h202, 3'd1);
    vt[8] = mkv(4, 21'h301, 21'h302, 21'h303, 21'h304, 3'd3);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_len", 64'(mem_len), 64'd0);
    check("rst_wvalid", 64'(mem_wvalid), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_full", 64'(fifo_full), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_flush_done", 64'(frame_flush_done), 64'd0);
    reset_n = 1;

    // first-burst shape table: memory stalls on ack until checked
    for (int v = 0; v < 9; v++) begin
      apply_reset();
      mode = 2;
      for (int i = 0; i < vt[v].n; i++) push_word(vt[v].a[i]);
      pulse_end();
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk);
        seen = mem_req;
      end
      check($sformatf("vec%0d_req", v), 64'(seen), 64'd1);
      check($sformatf("vec%0d_addr", v), 64'(mem_addr), 64'(vt[v].a[0]));
      check($sformatf("vec%0d_len", v), 64'(mem_len), 64'(vt[v].exp_len));
      mode = 0;
      wait_idle($sformatf("vec%0d_drain", v), 200);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_done_pulses", v), 64'(done_pulses), 64'd1);
    end

    // contiguous stream -> two full bursts
    apply_reset();
    mode = 0;
    for (int i = 0; i < 8; i++) push_word(21'h100 + 21'(i));
    wait_idle("contig_drain", 200);
    check("contig_nbursts", 64'(bursts.size()), 64'd2);
    if (bursts.size() == 2) begin
      check("contig_b0", {43'd0, bursts[0].addr}, 64'h100);
      check("contig_b0_len", 64'(bursts[0].len), 64'd4);
      check("contig_b1", {43'd0, bursts[1].addr}, 64'h104);
      check("contig_b1_len", 64'(bursts[1].len), 64'd4);
    end

    // misaligned and gapped
    apply_reset();
    push_word(21'h102); push_word(21'h103); push_word(21'h104); push_word(21'h200);
    wait_idle("gap_drain", 200);
    check("gap_nbursts", 64'(bursts.size()), 64'd3);
    if (bursts.size() == 3) begin
      check("gap_b0", {40'd0, bursts[0].len, bursts[0].addr}, {40'd0, 3'd2, 21'h102});
      check("gap_b1", {40'd0, bursts[1].len, bursts[1].addr}, {40'd0, 3'd1, 21'h104});
      check("gap_b2", {40'd0, bursts[2].len, bursts[2].addr}, {40'd0, 3'd1, 21'h200});
    end

    // backpressure: delayed ack, toggling wready
    apply_reset();
    mode = 3;
    for (int i = 0; i < 6; i++) push_word(21'h300 + 21'(i));
    wait_idle("bp_drain", 300);
    check("bp_pops", 64'(pops), 64'd6);
    mode = 0;

    // overflow
    apply_reset();
    mode = 2;
    for (int i = 0; i < 16; i++) push_word(21'h400 + 21'(i));
    check("ovf_full_at16", 64'(fifo_full), 64'd1);
    check("ovf_clear_at16", 64'(overflow), 64'd0);
    push_word(21'h410);
    check("ovf_set", 64'(overflow), 64'd1);
    mode = 0;
    wait_idle("ovf_drain", 300);
    check("ovf_pops", 64'(pops), 64'd16);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // flush with a redundant second end pulse
    apply_reset();
    push_word(21'h010); push_word(21'h011); push_word(21'h012);
    pulse_end();
    pulse_end();
    wait_idle("flush_drain", 100);
    repeat (3) @(negedge clk);
    check("flush_nbursts", 64'(bursts.size()), 64'd1);
    if (bursts.size() == 1)
      check("flush_b0", {40'd0, bursts[0].len, bursts[0].addr}, {40'd0, 3'd3, 21'h010});
    check("flush_pulses", 64'(done_pulses), 64'd1);

    // reset in the middle of a burst
    apply_reset();
    for (int i = 0; i < 4; i++) push_word(21'h500 + 21'(i));
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = mem_wvalid;
    end
    check("mid_rst_reached_data", 64'(seen), 64'd1);
    @(posedge clk); #1;
    reset_n = 0;
    #1;
    check("mid_rst_req", 64'(mem_req), 64'd0);
    check("mid_rst_wvalid", 64'(mem_wvalid), 64'd0);
    check("mid_rst_wdata", 64'(mem_wdata), 64'd0);
    check("mid_rst_addr", 64'(mem_addr), 64'd0);
    check("mid_rst_len", 64'(mem_len), 64'd0);
    @(posedge clk); #1;
    reset_n = 1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (mem_req || mem_wvalid) seen = 1;
    end
    check("mid_rst_no_stale", 64'(seen), 64'd0);

    // random traffic against the model
    apply_reset();
    mode = 1;
    ra = 21'($urandom);
    for (int c = 0; c < 800; c++) begin
      wr = ($urandom_range(0, 99) < 55);
      ra = ($urandom_range(0, 3) == 0) ? 21'($urandom) : ra + 21'd1;
      waddr = ra; wdin = $urandom;
      eolmb = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    wr = 0; eolmb = 0;
    pulse_end();
    mode = 0;
    wait_idle("rand_drain", 400);
    repeat (3) @(negedge clk);
    check("rand_done_seen", 64'(done_pulses > 0), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/df_frame_wb.md
# df_frame_wb

Write-back buffer between the deblocking filter's final-frame write port and the external frame memory. It absorbs the filter's single-word frame-store writes in a FIFO and coalesces address-contiguous words into bursts of up to 4 words. Bursts go out over a request/acknowledge plus valid/ready memory interface. It also signals when all pixels of the last macroblock of a picture have left the buffer.

## Interface

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries of {addr[20:0], data[31:0]}).
- TIMEOUT, 16, idle cycles a non-empty FIFO waits before a short burst is forced.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- final_frame_RAM_wr  in  1  write strobe from deblocking filter; one word per asserted cycle.
- final_frame_RAM_addr  in  21  word address of the write.
- final_frame_RAM_din  in  32  four packed pixels.
- end_of_lastMB_DF  in  1  one-cycle pulse: last macroblock of the picture is filtered.
- mem_req  out  1  burst request.
- mem_addr  out  21  burst start word address.
- mem_len  out  3  burst length, 1..4.
- mem_ack  in  1  request accepted; sampled only while mem_req=1.
- mem_wvalid  out  1  write data valid.
- mem_wdata  out  32  write data (FIFO head).
- mem_wready  in  1  memory accepts beat.
- fifo_full  out  1  FIFO count == 2^DEPTH_LOG2 (registered).
- overflow  out  1  sticky: a write was dropped.
- frame_flush_done  out  1  one-cycle pulse: picture fully written back.

## Operation

- FIFO: circular buffer with a count register (DEPTH_LOG2+1 bits). Push when final_frame_RAM_wr=1 and fifo_full=0.
- A write while fifo_full=1 is dropped and sets overflow. This holds even if a pop occurs in the same cycle. overflow clears only on reset.
- Push and pop in the same cycle leave the count unchanged.
- Burst length L is computed from the head entries:
  - Start with 4 − head_addr[1:0], so a burst never crosses a 4-word-aligned group.
  - Limit to count.
  - Limit further to the run of entries where addr[i+1] == addr[i]+1.
  - L ≥ 1 whenever count ≥ 1.
- FSM states are IDLE, REQ, DATA.
- IDLE launches a burst when any of these holds:
  - count ≥ 4, or
  - the contiguous run from the head already reaches the group end (full-length L), or
  - flush_pending=1 and count ≥ 1, or
  - the wait counter reaches TIMEOUT and count ≥ 1.
- On launch, IDLE latches mem_addr=head_addr and mem_len=L, then goes to REQ.
- REQ: mem_req=1, with mem_addr and mem_len held stable. When mem_ack=1, go to DATA with beat counter = L.
- DATA:
  - mem_wvalid=1 and mem_wdata = FIFO head.
  - Each cycle with mem_wvalid & mem_wready pops one entry and decrements the beat counter.
  - The last beat returns to IDLE.
- Wait counter: increments in IDLE while count ≥ 1 and no launch. Resets to 0 on launch or when count=0. It saturates at TIMEOUT.
- Flush:
  - end_of_lastMB_DF sets flush_pending.
  - When flush_pending=1, state=IDLE, count=0 and there is no push that cycle, the block pulses frame_flush_done for one cycle and clears flush_pending.
  - A second end_of_lastMB_DF while pending is absorbed (no extra pulse).
- Address arithmetic is 21-bit; the contiguity compare wraps modulo 2^21.

## Timing

- Reset values are all 0: every output, count, pointers, wait counter, flush_pending and overflow. State = IDLE.
- Asynchronous reset mid-burst abandons the burst and empties the FIFO.
- Push to earliest mem_req is 2 cycles:
  - Cycle 0: push registered.
  - Cycle 1: IDLE evaluates and latches.
  - Cycle 2: mem_req=1.
- mem_ack in the same cycle mem_req rises is legal; mem_wvalid rises the next cycle.
- Data beats can run back-to-back, one per cycle, when mem_wready stays 1.
- After the last beat, IDLE is reached the next cycle. A new mem_req cannot appear sooner than 1 cycle after that.
- fifo_full is updated from the post-push/pop count at the clock edge.
- frame_flush_done asserts at the earliest 1 cycle after the last beat's pop.

## Test plan

- Contiguous writes: 8 writes, addr 0x100..0x107, one per cycle, mem_ack and mem_wready tied 1 -> two bursts (0x100, len 4) and (0x104, len 4); mem_wdata in push order.
- Misaligned and gapped writes: addr 0x102, 0x103, 0x104, then 0x200, then idle -> burst (0x102, len 2), then after TIMEOUT idle cycles (0x104, len 1) and (0x200, len 1).
- Backpressure: mem_ack delayed 5 cycles and mem_wready toggled 1/0 -> mem_addr and mem_len stable through REQ; exactly mem_len pops; no data reorder.
- Overflow: mem_ack held 0, 17 writes -> fifo_full=1 after 16; 17th write dropped; overflow=1 until reset; the 16 stored words later drain intact.
- Flush: 3 writes at 0x10..0x12, then end_of_lastMB_DF -> burst (0x10, len 3) immediately without timeout; frame_flush_done pulses once, one cycle after the final beat.
- Reset mid-burst: assert reset_n=0 during DATA beat 2 -> all outputs 0 asynchronously; after release, count=0 and no stale mem_req.
